// File: rtl/key_pkg.sv
// key_pkg: shared state encoding and sizing helpers for the key debounce slice.
package key_pkg;

  typedef enum logic [1:0] {
    RELEASED   = 2'b00,
    DB_PRESS   = 2'b01,
    PRESSED    = 2'b10,
    DB_RELEASE = 2'b11
  } key_state_e;

  // Converts a duration in milliseconds to sys_clk cycles.
  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                               input int unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

  // Counter width that can hold n without wrapping.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one key channel -- 2-FF synchronizer, debounce FSM,
// long-press timer. Optional auto-repeat is enabled by KEY_AUTO_REPEAT_EN.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned DB_CNT = 4,
  parameter int unsigned LP_CNT = 20,
`ifdef KEY_AUTO_REPEAT_EN
  parameter int unsigned RP_CNT = 5,
`endif
  parameter int unsigned CW     = 6
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic key_n_i,
  output logic key_level_o,
  output logic press_pulse_o,
  output logic release_pulse_o,
  output logic long_press_o
);

  localparam logic [CW-1:0] DB_MAX = CW'(DB_CNT);
  localparam logic [CW-1:0] LP_MAX = CW'(LP_CNT);

  logic [1:0]    sync;
  logic          s;
  key_state_e    state;
  logic [CW-1:0] db_cnt;
  logic [CW-1:0] lp_cnt;
  logic          long_done;

  assign s = sync[1];

  // Two-flop synchronizer; idles high so reset looks like a released key.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], key_n_i};
  end

`ifdef KEY_AUTO_REPEAT_EN
  localparam int unsigned   RW     = cnt_width(RP_CNT);
  localparam logic [RW-1:0] RP_MAX = RW'(RP_CNT);
  logic [RW-1:0] rp_cnt;
  logic          rp_fire;

  // Repeat timer: runs only while held after the long press, pauses during
  // release debounce, clears once the key is fully released.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      rp_cnt  <= '0;
    end else if (state == RELEASED || state == DB_PRESS) begin
      rp_cnt  <= '0;
    end else if (state == PRESSED && !s && long_done) begin
      if (rp_cnt + RW'(1) == RP_MAX) rp_cnt <= '0;
      else                            rp_cnt <= rp_cnt + RW'(1);
    end
  end

  assign rp_fire = (state == PRESSED) && !s && long_done &&
                   (rp_cnt + RW'(1) == RP_MAX);
`else
  logic rp_fire;
  assign rp_fire = 1'b0;
`endif

  // Debounce FSM with registered level and one-cycle event pulses.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state           <= RELEASED;
      db_cnt          <= '0;
      lp_cnt          <= '0;
      long_done       <= 1'b0;
      key_level_o     <= 1'b1;
      press_pulse_o   <= 1'b0;
      release_pulse_o <= 1'b0;
      long_press_o    <= 1'b0;
    end else begin
      press_pulse_o   <= rp_fire;
      release_pulse_o <= 1'b0;
      long_press_o    <= 1'b0;
      case (state)
        RELEASED: begin
          if (!s) begin
            state  <= DB_PRESS;
            db_cnt <= CW'(1);
          end
        end
        DB_PRESS: begin
          if (s) begin
            state  <= RELEASED;
            db_cnt <= '0;
          end else if (db_cnt + CW'(1) == DB_MAX) begin
            state         <= PRESSED;
            db_cnt        <= '0;
            key_level_o   <= 1'b0;
            press_pulse_o <= 1'b1;
            lp_cnt        <= '0;
            long_done     <= 1'b0;
          end else begin
            db_cnt <= db_cnt + CW'(1);
          end
        end
        PRESSED: begin
          if (s) begin
            // Long counter is left untouched so a release bounce resumes it.
            state  <= DB_RELEASE;
            db_cnt <= CW'(1);
          end else begin
            if (lp_cnt != LP_MAX) lp_cnt <= lp_cnt + CW'(1);
            if (lp_cnt + CW'(1) == LP_MAX && !long_done) begin
              long_press_o <= 1'b1;
              long_done    <= 1'b1;
            end
          end
        end
        DB_RELEASE: begin
          if (!s) begin
            state  <= PRESSED;
            db_cnt <= '0;
          end else if (db_cnt + CW'(1) == DB_MAX) begin
            state           <= RELEASED;
            db_cnt          <= '0;
            key_level_o     <= 1'b1;
            release_pulse_o <= 1'b1;
          end else begin
            db_cnt <= db_cnt + CW'(1);
          end
        end
        default: state <= RELEASED;
      endcase
    end
  end

endmodule

// File: rtl/key_debounce.sv
// key_debounce: NUM_KEYS independent debounce channels for active-low keys.
// Optional auto-repeat of press pulses is enabled by KEY_AUTO_REPEAT_EN.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS      = 2,
  parameter int unsigned CLK_FREQ_HZ   = 50_000_000,
  parameter int unsigned DEBOUNCE_MS   = 20,
`ifdef KEY_AUTO_REPEAT_EN
  parameter int unsigned REPEAT_MS     = 200,
`endif
  parameter int unsigned LONG_PRESS_MS = 1000
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_n_i,
  output logic [NUM_KEYS-1:0] key_level_o,
  output logic [NUM_KEYS-1:0] press_pulse_o,
  output logic [NUM_KEYS-1:0] release_pulse_o,
  output logic [NUM_KEYS-1:0] long_press_o
);

  localparam int unsigned DB_CNT = ms_to_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);
  localparam int unsigned LP_CNT = ms_to_cycles(CLK_FREQ_HZ, LONG_PRESS_MS);
  localparam int unsigned CW     = cnt_width(LP_CNT);
`ifdef KEY_AUTO_REPEAT_EN
  localparam int unsigned RP_CNT = ms_to_cycles(CLK_FREQ_HZ, REPEAT_MS);
`endif

  // One channel per key; channels share only clock and reset.
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DB_CNT (DB_CNT),
      .LP_CNT (LP_CNT),
`ifdef KEY_AUTO_REPEAT_EN
      .RP_CNT (RP_CNT),
`endif
      .CW     (CW)
    ) u_ch (
      .sys_clk         (sys_clk),
      .rst             (rst),
      .key_n_i         (key_n_i[i]),
      .key_level_o     (key_level_o[i]),
      .press_pulse_o   (press_pulse_o[i]),
      .release_pulse_o (release_pulse_o[i]),
      .long_press_o    (long_press_o[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed stimulus with an event scoreboard for key_debounce.
// Build with KEY_AUTO_REPEAT_EN defined to exercise auto-repeat.
module tb_key_debounce;

  typedef struct {
    int cyc;
    int ch;
    int kind;  // 0 press, 1 release, 2 long
  } ev_t;

  logic       sys_clk = 1'b0;
  logic       rst     = 1'b1;
  logic [1:0] key_n   = 2'b11;
  logic [1:0] key_level_o, press_pulse_o, release_pulse_o, long_press_o;

  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  ev_t  exp_q[$];
  logic [1:0] exp_level = 2'b11;

  key_debounce #(
    .NUM_KEYS      (2),
    .CLK_FREQ_HZ   (1000),
    .DEBOUNCE_MS   (4),
`ifdef KEY_AUTO_REPEAT_EN
    .REPEAT_MS     (5),
`endif
    .LONG_PRESS_MS (20)
  ) dut (
    .sys_clk         (sys_clk),
    .rst             (rst),
    .key_n_i         (key_n),
    .key_level_o     (key_level_o),
    .press_pulse_o   (press_pulse_o),
    .release_pulse_o (release_pulse_o),
    .long_press_o    (long_press_o)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic push(input int c, input int ch, input int kind);
    ev_t e;
    e.cyc = c; e.ch = ch; e.kind = kind;
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle, compare outputs against scoreboard events due now.
  always @(negedge sys_clk) begin
    logic [1:0] ep, er, el;
    if (rst) begin
      exp_level = 2'b11;
      n_assert++;
      assert ({key_level_o, press_pulse_o, release_pulse_o, long_press_o} === 8'b11_00_00_00)
      else begin
        n_fail++;
        $error("FAIL reset_state cyc=%0d got=%b expected=%b", cyc,
               {key_level_o, press_pulse_o, release_pulse_o, long_press_o}, 8'b11_00_00_00);
      end
    end else begin
      ep = '0; er = '0; el = '0;
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].cyc == cyc) begin
          case (exp_q[i].kind)
            0: begin ep[exp_q[i].ch] = 1'b1; exp_level[exp_q[i].ch] = 1'b0; end
            1: begin er[exp_q[i].ch] = 1'b1; exp_level[exp_q[i].ch] = 1'b1; end
            default: el[exp_q[i].ch] = 1'b1;
          endcase
          exp_q.delete(i);
        end
      end
      n_assert++;
      assert (press_pulse_o === ep) else begin
        n_fail++;
        $error("FAIL press_pulse cyc=%0d got=%b expected=%b", cyc, press_pulse_o, ep);
      end
      n_assert++;
      assert (release_pulse_o === er) else begin
        n_fail++;
        $error("FAIL release_pulse cyc=%0d got=%b expected=%b", cyc, release_pulse_o, er);
      end
      n_assert++;
      assert (long_press_o === el) else begin
        n_fail++;
        $error("FAIL long_press cyc=%0d got=%b expected=%b", cyc, long_press_o, el);
      end
      n_assert++;
      assert (key_level_o === exp_level) else begin
        n_fail++;
        $error("FAIL key_level cyc=%0d got=%b expected=%b", cyc, key_level_o, exp_level);
      end
    end
  end

  initial begin
    int p, r;
    tick(3);
    rst = 1'b0;
    tick(8);

    // Clean press and release on key 0.
    key_n[0] = 1'b0; push(cyc + 6, 0, 0);
    tick(10);
    key_n[0] = 1'b1; push(cyc + 6, 0, 1);
    tick(10);

    // Press bounce: low 3, high 1, low held.
    key_n[0] = 1'b0;
    tick(3);
    key_n[0] = 1'b1;
    tick(1);
    key_n[0] = 1'b0; push(cyc + 6, 0, 0);
    tick(10);
    key_n[0] = 1'b1; push(cyc + 6, 0, 1);
    tick(10);

    // Long press: hold 40 cycles after accept.
    key_n[0] = 1'b0;
    p = cyc + 6;
    push(p, 0, 0);
    push(p + 20, 0, 2);
    tick(6 + 40);
    key_n[0] = 1'b1;
    r = cyc;
    push(r + 6, 0, 1);
`ifdef KEY_AUTO_REPEAT_EN
    for (int k = p + 25; k <= r + 2; k += 5) push(k, 0, 0);
`endif
    tick(12);

    // Release bounce: pin returns low for one cycle during release debounce.
    key_n[0] = 1'b0; push(cyc + 6, 0, 0);
    tick(6 + 5);
    key_n[0] = 1'b1;
    tick(2);
    key_n[0] = 1'b0;
    tick(1);
    key_n[0] = 1'b1; push(cyc + 6, 0, 1);
    tick(10);

    // Simultaneous press and release on both keys.
    key_n = 2'b00; push(cyc + 6, 0, 0); push(cyc + 6, 1, 0);
    tick(10);
    key_n = 2'b11; push(cyc + 6, 0, 1); push(cyc + 6, 1, 1);
    tick(10);

    // Reset asserted mid-press on key 1, key held low through reset release.
    key_n[1] = 1'b0; push(cyc + 6, 1, 0);
    tick(8);
    #2 rst = 1'b1;
    #1;
    n_assert++;
    assert ({key_level_o, press_pulse_o, release_pulse_o, long_press_o} === 8'b11_00_00_00)
    else begin
      n_fail++;
      $error("FAIL async_reset cyc=%0d got=%b expected=%b", cyc,
             {key_level_o, press_pulse_o, release_pulse_o, long_press_o}, 8'b11_00_00_00);
    end
    tick(3);
    rst = 1'b0; push(cyc + 6, 1, 0);
    tick(10);
    key_n[1] = 1'b1; push(cyc + 6, 1, 1);
    tick(10);

    tick(5);
    n_assert++;
    assert (exp_q.size() === 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain got=%0d pending expected=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
